// File: rtl/linebuf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : linebuf_pkg
//  Purpose  : Shared width defaults and the bank-select type for the
//             double-buffered scanline buffer (linebuf_prio).
//  Contents : LB_DATA_W / LB_IDX_W / LB_OUT_W default widths, bank_sel_t.
//  Revision : 1.0 - initial release
// ============================================================================
package linebuf_pkg;

  localparam int LB_DATA_W = 8;  // stored pixel width
  localparam int LB_IDX_W  = 8;  // pixel index width (depth = 2**IDX_W)
  localparam int LB_OUT_W  = 5;  // display output width

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_sel_t;

endpackage : linebuf_pkg
`default_nettype wire

// File: rtl/linebuf_bank.sv
`default_nettype none
// ============================================================================
//  Module   : linebuf_bank
//  Purpose  : One scanline bank: simple dual-port RAM (write port plus
//             registered read port) with a per-pixel occupancy flop array.
//  Ports    : clk, rst_n      - clock, async active-low reset (flags only)
//             clr             - clear every occupancy flag this edge
//             we/wr_idx/wr_data - pixel write; sets that pixel's flag
//                               (applied after clr on the same edge)
//             hit             - current occupancy of wr_idx (combinational)
//             rd_idx          - read index
//             rd_data         - registered RAM word at rd_idx
//             rd_occ          - registered occupancy flag of rd_idx
//  Revision : 1.0 - initial release
// ============================================================================
module linebuf_bank #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic              hit,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_occ
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DEPTH-1:0]  occ_q, occ_d;
  logic              rd_occ_q, rd_occ_d;

  // Clear first so a write on the clearing edge survives as the only flag.
  always_comb begin
    occ_d = occ_q;
    if (clr) occ_d = '0;
    if (we)  occ_d[wr_idx] = 1'b1;
    rd_occ_d = occ_q[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= '0;
      rd_occ_q <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      rd_occ_q <= rd_occ_d;
    end
  end

  // RAM contents are never reset; the occupancy flags decide visibility.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
    rd_data_q <= mem[rd_idx];
  end

  assign hit     = occ_q[wr_idx];
  assign rd_data = rd_data_q;
  assign rd_occ  = rd_occ_q;

endmodule : linebuf_bank
`default_nettype wire

// File: rtl/linebuf_prio.sv
`default_nettype none
// ============================================================================
//  Module   : linebuf_prio
//  Purpose  : Double-buffered scanline buffer. The render side writes bank
//             `linesel` with first-write-wins priority; the display side reads
//             bank `!linesel` with one cycle latency. A bank is logically
//             cleared on the cycle it becomes the render bank.
//  Ports    : clk, rst_n        - clock, async active-low reset
//             linesel           - render bank select (display = !linesel)
//             wr_idx/wr_data/wr_en/wr_force - render write request
//             wr_ok             - registered: last request actually wrote
//             rd_idx            - display read index
//             rd_data/rd_valid  - registered pixel (0 if unoccupied) + flag
//             collision         - (LINEBUF_COLLISION_EN only) sticky flag set
//                                 by a dropped unforced overlap, cleared on
//                                 a bank swap
//  Options  : `define LINEBUF_COLLISION_EN adds the collision output.
//  Revision : 1.0 - initial release
// ============================================================================
module linebuf_prio
  import linebuf_pkg::*;
#(
  parameter int DATA_W = LB_DATA_W,
  parameter int IDX_W  = LB_IDX_W,
  parameter int OUT_W  = LB_OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              linesel,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              wr_force,
  output logic              wr_ok,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [OUT_W-1:0]  rd_data,
  output logic              rd_valid
`ifdef LINEBUF_COLLISION_EN
  ,
  output logic              collision
`endif
);

  logic        linesel_q, linesel_d;
  bank_sel_t   rd_sel_q, rd_sel_d;
  logic        wr_ok_q, wr_ok_d;

  logic        swap;
  logic        hit;
  logic        do_wr;
  logic [1:0]  bank_hit;
  logic [1:0]  bank_we;
  logic [1:0]  bank_clr;
  logic [1:0]  bank_rd_occ;
  logic [DATA_W-1:0] bank_rd_data [2];
  logic [DATA_W-1:0] rd_word;
  logic              unused_rd_word;

  always_comb begin
    swap      = linesel ^ linesel_q;
    // The render bank is being cleared this edge, so its stale flags
    // must not block the request.
    hit       = swap ? 1'b0 : bank_hit[linesel];
    do_wr     = wr_en & (wr_force | ~hit);
    bank_we   = {do_wr & linesel, do_wr & ~linesel};
    bank_clr  = {swap & linesel, swap & ~linesel};
    linesel_d = linesel;
    rd_sel_d  = bank_sel_t'(~linesel);
    wr_ok_d   = do_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      linesel_q <= 1'b0;
      rd_sel_q  <= BANK_1;
      wr_ok_q   <= 1'b0;
    end else begin
      linesel_q <= linesel_d;
      rd_sel_q  <= rd_sel_d;
      wr_ok_q   <= wr_ok_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    linebuf_bank #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (bank_clr[b]),
      .we      (bank_we[b]),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .hit     (bank_hit[b]),
      .rd_idx  (rd_idx),
      .rd_data (bank_rd_data[b]),
      .rd_occ  (bank_rd_occ[b])
    );
  end : g_bank

  // rd_sel_q remembers which bank was the display bank when the read was
  // issued, so both outputs line up with the registered bank read data.
  assign rd_word        = bank_rd_data[rd_sel_q];
  assign rd_valid       = bank_rd_occ[rd_sel_q];
  assign rd_data        = rd_valid ? rd_word[OUT_W-1:0] : '0;
  assign unused_rd_word = ^rd_word;
  assign wr_ok          = wr_ok_q;

`ifdef LINEBUF_COLLISION_EN
  logic collision_q, collision_d;

  always_comb begin
    collision_d = swap ? 1'b0 : (collision_q | (wr_en & ~wr_force & hit));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision_q <= 1'b0;
    else        collision_q <= collision_d;
  end

  assign collision = collision_q;
`endif

endmodule : linebuf_prio
`default_nettype wire

// File: tb/tb_linebuf_prio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_linebuf_prio
//  Purpose  : Self-checking bench for linebuf_prio. Stimulus pushes expected
//             responses into queues; a monitor pops and compares them after
//             each rising edge.
//  Options  : `define LINEBUF_COLLISION_EN to also check the collision flag.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_linebuf_prio;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       linesel;
  logic [7:0] wr_idx;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       wr_force;
  logic       wr_ok;
  logic [7:0] rd_idx;
  logic [4:0] rd_data;
  logic       rd_valid;
`ifdef LINEBUF_COLLISION_EN
  logic       collision;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [4:0] data;
    logic       valid;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  logic    wr_q[$];
  logic    col_q[$];
  logic    rd_req = 1'b0;
  logic    wr_req = 1'b0;
  logic    col_req = 1'b0;

  always #5 clk = ~clk;

  linebuf_prio #(
    .DATA_W (8),
    .IDX_W  (8),
    .OUT_W  (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .linesel  (linesel),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .wr_force (wr_force),
    .wr_ok    (wr_ok),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
`ifdef LINEBUF_COLLISION_EN
    ,
    .collision(collision)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the stimulus flagged for the edge just taken.
  always @(posedge clk) begin
    logic p_rd, p_wr, p_col;
    rd_exp_t e;
    p_rd  = rd_req;
    p_wr  = wr_req;
    p_col = col_req;
    #1;
    if (p_rd) begin
      e = rd_q.pop_front();
      check("rd_data", 32'(rd_data), 32'(e.data));
      check("rd_valid", 32'(rd_valid), 32'(e.valid));
    end
    if (p_wr) check("wr_ok", 32'(wr_ok), 32'(wr_q.pop_front()));
`ifdef LINEBUF_COLLISION_EN
    if (p_col) check("collision", 32'(collision), 32'(col_q.pop_front()));
`endif
  end

  task automatic exp_rd(input logic [4:0] d, input logic v);
    rd_exp_t e;
    e.data  = d;
    e.valid = v;
    rd_q.push_back(e);
    rd_req = 1'b1;
  endtask

  task automatic exp_wr(input logic ok);
    wr_q.push_back(ok);
    wr_req = 1'b1;
  endtask

  task automatic exp_col(input logic c);
`ifdef LINEBUF_COLLISION_EN
    col_q.push_back(c);
    col_req = 1'b1;
`else
    if (c) col_req = 1'b0;
`endif
  endtask

  // Drive one cycle of inputs (called just after a falling edge).
  task automatic drive(input logic ls, input logic we, input logic frc,
                       input logic [7:0] wi, input logic [7:0] wd, input logic [7:0] ri);
    linesel  = ls;
    wr_en    = we;
    wr_force = frc;
    wr_idx   = wi;
    wr_data  = wd;
    rd_idx   = ri;
  endtask

  task automatic tick();
    @(negedge clk);
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    col_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    #3;
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);
    check("reset wr_ok", 32'(wr_ok), 32'd0);
`ifdef LINEBUF_COLLISION_EN
    check("reset collision", 32'(collision), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic write then read across a swap.
    drive(1'b0, 1'b1, 1'b0, 8'd5, 8'h1F, 8'd0); exp_wr(1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'd5); exp_rd(5'h1F, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'd6); exp_rd(5'h00, 1'b0); tick();

    // First write wins (render bank 1).
    drive(1'b1, 1'b1, 1'b0, 8'd10, 8'h03, 8'd0); exp_wr(1'b1); exp_col(1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 8'd10, 8'h07, 8'd0); exp_wr(1'b0); exp_col(1'b1); tick();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 8'd10); exp_rd(5'h03, 1'b1); exp_col(1'b0); tick();

    // Forced overwrite (render bank 0, just cleared).
    drive(1'b0, 1'b1, 1'b0, 8'd10, 8'h03, 8'd0); exp_wr(1'b1); exp_col(1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 8'd10, 8'h07, 8'd0); exp_wr(1'b1); exp_col(1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'd10); exp_rd(5'h07, 1'b1); tick();

    // Sticky collision on idx 3 (render bank 1).
    drive(1'b1, 1'b1, 1'b0, 8'd3, 8'h01, 8'd0); exp_wr(1'b1); exp_col(1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 8'd3, 8'h02, 8'd0); exp_wr(1'b0); exp_col(1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'd0); exp_col(1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'd0); exp_col(1'b1); tick();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 8'd3); exp_rd(5'h01, 1'b1); exp_col(1'b0); tick();

    // Unforced write on a swap cycle ignores the stale flag of idx 3 in bank 1.
    drive(1'b1, 1'b1, 1'b0, 8'd3, 8'h0A, 8'd0); exp_wr(1'b1); exp_col(1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 8'd3); exp_rd(5'h0A, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 8'd4); exp_rd(5'h00, 1'b0); tick();

    // Fill bank 0 completely, then swap away and back.
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'(i), 8'(i), 8'd0); exp_wr(1'b1); tick();
    end
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'd9); exp_rd(5'h09, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 8'd0); tick();
    // Bank 1 was cleared when it became render and never written.
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 8'(i)); exp_rd(5'h00, 1'b0); tick();
    end
    // Bank 0 was cleared when it became render again.
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'(i)); exp_rd(5'h00, 1'b0); tick();
    end

    // Swap-cycle write: bank 0 ends with only idx 0 occupied.
    drive(1'b0, 1'b1, 1'b0, 8'd0, 8'h11, 8'd0); exp_wr(1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'd0); exp_rd(5'h11, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'd1); exp_rd(5'h00, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'd200); exp_rd(5'h00, 1'b0); tick();

    // Asynchronous reset between edges while outputs are active.
    drive(1'b1, 1'b1, 1'b0, 8'd7, 8'h05, 8'd0); exp_wr(1'b1); exp_rd(5'h11, 1'b1); tick();
    drive(1'b1, 1'b1, 1'b0, 8'd7, 8'h06, 8'd0); exp_wr(1'b0); exp_col(1'b1); exp_rd(5'h11, 1'b1); tick();
    drive(1'b1, 1'b1, 1'b0, 8'd8, 8'h06, 8'd0); exp_wr(1'b1); exp_rd(5'h11, 1'b1); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async rd_valid", 32'(rd_valid), 32'd0);
    check("async rd_data", 32'(rd_data), 32'd0);
    check("async wr_ok", 32'(wr_ok), 32'd0);
`ifdef LINEBUF_COLLISION_EN
    check("async collision", 32'(collision), 32'd0);
`endif
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'd0);
    tick();
    tick();
    rst_n = 1'b1;
    // Bank 0 flags are only cleared by the reset here (it stays display).
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'd0); exp_rd(5'h00, 1'b0); exp_wr(1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'd5); exp_rd(5'h00, 1'b0); tick();
    tick();

    if (rd_q.size() != 0 || wr_q.size() != 0 || col_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: %0d/%0d/%0d entries left, expected 0",
               rd_q.size(), wr_q.size(), col_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_linebuf_prio
`default_nettype wire

// File: doc/linebuf_prio.md
Name: linebuf_prio

Overview:
- Parametrised double-buffered scanline buffer for the aqms video path.
- The sprite/render engine writes one line into the render bank while the display pipeline reads the previous line from the display bank.
- Adds three things the fixed 8-bit/256-entry buffer lacks:
  - per-pixel occupancy flags with first-write-wins priority;
  - automatic logical clear of a bank when it becomes the render bank;
  - parametrised data width, depth and output width.

Parameters:
- DATA_W, 8, stored pixel width in bits.
- IDX_W, 8, pixel index width; depth per bank is 2**IDX_W.
- OUT_W, 5, display output width; rd_data = stored[OUT_W-1:0]; OUT_W <= DATA_W.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- linesel  in  1  bank select: render bank = linesel, display bank = !linesel.
- wr_idx  in  IDX_W  render write pixel index.
- wr_data  in  DATA_W  render write data.
- wr_en  in  1  write request, one per cycle max.
- wr_force  in  1  with wr_en: write even if the pixel is occupied.
- wr_ok  out  1  registered: previous cycle's wr_en actually wrote.
- rd_idx  in  IDX_W  display read index.
- rd_data  out  OUT_W  display pixel; 0 if the pixel is unoccupied.
- rd_valid  out  1  registered occupancy flag of the pixel returned on rd_data.

Behaviour:
- Storage:
  - Two banks of 2**IDX_W x DATA_W, inferred block RAM; data is never cleared.
  - Two occupancy arrays occ[bank][2**IDX_W] held in flops.
- Reset, asynchronous: occ = all 0, linesel_q = 0, rd_data = 0, rd_valid = 0, wr_ok = 0, collision = 0. RAM contents are undefined after reset.
- Swap detect: swap = (linesel != linesel_q); linesel_q <= linesel every cycle.
- On a swap cycle, occ[linesel] is cleared in full on that edge. The new render bank therefore reads as empty from the next cycle on.
- Render write, decided combinationally in the request cycle:
  - hit = occ[linesel][wr_idx], evaluated as 0 on a swap cycle.
  - do_wr = wr_en & (wr_force | !hit).
  - If do_wr: RAM[linesel][wr_idx] <= wr_data and occ[linesel][wr_idx] <= 1.
  - wr_ok <= do_wr.
- On a swap cycle with wr_en, the write applies after the clear. The result is a bank with only that pixel occupied, and wr_ok = 1.
- Back-to-back writes to the same index: the second sees the first's flag, since flops need no forwarding. A non-forced second write is dropped.
- Display read, latency 1:
  - Registers rd_valid <= occ[!linesel][rd_idx].
  - rd_data <= occ ? RAM[!linesel][rd_idx][OUT_W-1:0] : 0.
  - On a swap cycle the read uses the new !linesel bank. Flags of the display bank are never touched by the clear.
- The render and display ports always address different banks, so no RAM collision handling is needed.
- Out-of-range conditions are impossible: the index width equals the depth.
- No back-pressure; all inputs are accepted every cycle.

Optional Feature:
- Macro: LINEBUF_COLLISION_EN.
- When defined:
  - Adds output `collision` (1 bit, registered, reset 0).
  - Set when wr_en & !wr_force & hit, meaning a sprite overlapped an already-written pixel.
  - Sticky until a swap cycle, which clears it. If a collision occurs on the swap cycle itself, it is not flagged because hit is forced to 0.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package linebuf_pkg holds:
  - default width constants (LB_DATA_W = 8, LB_IDX_W = 8, LB_OUT_W = 5);
  - a typedef for bank select.
- One sub-module, linebuf_bank: a single simple dual-port RAM (write port + registered read port) with its occupancy flop array, a clear input and a hit output. The top instantiates two and muxes by linesel.

Test Plan:
- Reset then linesel = 0:
  - Write idx 5 = 0x1F, toggle linesel to 1, read idx 5 -> next cycle rd_data = 0x1F, rd_valid = 1.
  - Read idx 6 -> rd_data = 0, rd_valid = 0.
- Priority:
  - Write idx 10 = 0x03, then idx 10 = 0x07 unforced -> wr_ok 1 then 0; after swap, rd_data = 0x03.
  - Repeat with wr_force = 1 -> rd_data = 0x07.
- Clear on swap:
  - Fill bank 0, swap to 1, swap back to 0, read bank 1 view -> every index rd_valid = 0.
  - Old data in bank 0 is not visible once rewritten, and occupancy is empty.
- Swap-cycle write: toggle linesel and assert wr_en idx 0 = 0x11 in the same cycle -> wr_ok = 1; after the next swap only idx 0 reads valid.
- Async reset mid-line: assert rst_n low between clock edges during writes -> rd_valid, wr_ok and collision go 0 immediately; occupancy reads empty after release.
- LINEBUF_COLLISION_EN:
  - Two unforced writes to idx 3 -> collision = 1 one cycle after the second, and stays 1; cleared on the next swap.
  - A forced overlap does not set it.
